// File: rtl/maindec_pipe.sv
// maindec_pipe: registered, handshaked main decoder for the RegStage controller.
// Decodes opcode+funct3 into the 13-bit control bundle, flags illegal encodings,
// stalls the front end while a FENCE drains and holds in TRAP after SYSTEM/illegal.
//
//   state | meaning
//   RUN   | normal decode, in_ready follows the output handshake
//   DRAIN | FENCE accepted, in_ready low until the drain counter expires
//   TRAP  | SYSTEM/illegal accepted, in_ready low until trap_ack
module maindec_pipe #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = $clog2(DRAIN_CYCLES + 1),
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       flush,
    input  logic       trap_ack,
    output logic       RegWrite,
    output logic [2:0] ImmSrc,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic       Branch,
    output logic [1:0] ALUOp,
    output logic       Jump,
    output logic       MemRead,
    output logic       illegal,
    output logic       is_fence,
    output logic       is_system,
    output logic       busy
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [12:0]       ctrl_q;
    logic              illegal_q;
    logic              fence_q;
    logic              system_q;

    // bundle order: {RegWrite,ImmSrc,ALUSrc,MemWrite,ResultSrc,Branch,ALUOp,Jump,MemRead}
    logic [12:0]       ctrl_d;
    logic              illegal_d;
    logic              fence_d;
    logic              system_d;
    logic              accept;

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // combinational decode of the presented instruction; illegal encodings yield all-zero controls
    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        fence_d   = 1'b0;
        system_d  = 1'b0;
        case (op)
            OP_LOAD: begin
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    illegal_d = 1'b1;
                else
                    ctrl_d = 13'b1_000_1_0_01_0_00_0_1;
            end
            OP_STORE: begin
                if (funct3 >= 3'b011)
                    illegal_d = 1'b1;
                else
                    ctrl_d = 13'b0_001_1_1_00_0_00_0_0;
            end
            OP_OP:     ctrl_d = 13'b1_000_0_0_00_0_10_0_0;
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    illegal_d = 1'b1;
                else
                    ctrl_d = 13'b0_010_0_0_00_1_10_0_0;
            end
            OP_OPIMM:  ctrl_d = 13'b1_000_1_0_00_0_10_0_0;
            OP_JAL:    ctrl_d = 13'b1_011_0_0_10_0_00_1_0;
            OP_JALR: begin
                if (funct3 != 3'b000)
                    illegal_d = 1'b1;
                else
                    ctrl_d = 13'b1_000_1_0_10_0_00_1_0;
            end
            OP_AUIPC:  ctrl_d = 13'b1_100_0_0_11_0_00_0_0;
            OP_LUI:    ctrl_d = 13'b1_100_1_0_00_0_11_0_0;
            OP_FENCE:  fence_d  = 1'b1;
            OP_SYSTEM: system_d = 1'b1;
            default:   illegal_d = 1'b1;
        endcase
    end

    // output register and RUN/DRAIN/TRAP sequencing; flush overrides everything but reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            fence_q     <= 1'b0;
            system_q    <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            fence_q     <= 1'b0;
            system_q    <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                ctrl_q      <= ctrl_d;
                illegal_q   <= illegal_d;
                fence_q     <= fence_d;
                system_q    <= system_d;
            end else if (out_valid_q && out_ready) begin
                // bundle contents stay put so Ex sees stable controls after consumption
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_RUN: begin
                    if (accept && fence_d) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CNT_W'(DRAIN_CYCLES);
                    end else if (accept && ILLEGAL_TRAP && (system_d || illegal_d)) begin
                        state_q <= ST_TRAP;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_TRAP: begin
                    if (trap_ack)
                        state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, MemRead} = ctrl_q;
    assign illegal   = illegal_q;
    assign is_fence  = fence_q;
    assign is_system = system_q;
    assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_maindec_pipe.sv
// Directed bench for maindec_pipe: handshake, decode table, FENCE drain, trap hold,
// flush and asynchronous reset.
module tb_maindec_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic       trap_ack;
    logic       RegWrite;
    logic [2:0] ImmSrc;
    logic       ALUSrc;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic       Branch;
    logic [1:0] ALUOp;
    logic       Jump;
    logic       MemRead;
    logic       illegal;
    logic       is_fence;
    logic       is_system;
    logic       busy;

    logic [12:0] ctrl;
    assign ctrl = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, MemRead};

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [12:0] C_LOAD   = 13'b1_000_1_0_01_0_00_0_1;
    localparam logic [12:0] C_STORE  = 13'b0_001_1_1_00_0_00_0_0;
    localparam logic [12:0] C_OP     = 13'b1_000_0_0_00_0_10_0_0;
    localparam logic [12:0] C_BRANCH = 13'b0_010_0_0_00_1_10_0_0;
    localparam logic [12:0] C_OPIMM  = 13'b1_000_1_0_00_0_10_0_0;
    localparam logic [12:0] C_JAL    = 13'b1_011_0_0_10_0_00_1_0;
    localparam logic [12:0] C_JALR   = 13'b1_000_1_0_10_0_00_1_0;
    localparam logic [12:0] C_AUIPC  = 13'b1_100_0_0_11_0_00_0_0;
    localparam logic [12:0] C_LUI    = 13'b1_100_1_0_00_0_11_0_0;

    maindec_pipe #(.DRAIN_CYCLES(4), .ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct3(funct3), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .trap_ack(trap_ack), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
        .ALUSrc(ALUSrc), .MemWrite(MemWrite), .ResultSrc(ResultSrc), .Branch(Branch),
        .ALUOp(ALUOp), .Jump(Jump), .MemRead(MemRead), .illegal(illegal),
        .is_fence(is_fence), .is_system(is_system), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one instruction for a single edge, then withdraw it
    task automatic issue(input logic [6:0] o, input logic [2:0] f3);
        op = o; funct3 = f3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // accept a trapping instruction, confirm the hold, then release with trap_ack
    task automatic trap_case(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic exp_ill, input logic exp_sys);
        out_ready = 1'b1;
        issue(o, f3);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        chk({tag, "_system"}, 32'(is_system), 32'(exp_sys));
        chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        tick(); tick(); tick();
        chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
        chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        chk({tag, "_rel_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [6:0]  o;
        logic [2:0]  f3;
        logic [12:0] c;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   low_cnt;

        reset = 1'b1; in_valid = 1'b0; op = '0; funct3 = '0;
        out_ready = 1'b0; flush = 1'b0; trap_ack = 1'b0;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_flags", 32'({illegal, is_fence, is_system}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rst_rdy", 32'(in_ready), 32'd1);

        // LUI with out_ready high: registered one edge later
        out_ready = 1'b1;
        issue(7'b0110111, 3'b000);
        chk("lui_valid", 32'(out_valid), 32'd1);
        chk("lui_ctrl", 32'(ctrl), 32'(C_LUI));
        tick();
        chk("lui_consumed", 32'(out_valid), 32'd0);
        chk("lui_ctrl_kept", 32'(ctrl), 32'(C_LUI));

        // LOAD then STORE under a 3-cycle stall
        out_ready = 1'b0;
        issue(7'b0000011, 3'b010);
        chk("load_ctrl", 32'(ctrl), 32'(C_LOAD));
        op = 7'b0100011; funct3 = 3'b010; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", 32'(in_ready), 32'd0);
            tick();
            chk("stall_hold", 32'(ctrl), 32'(C_LOAD));
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("store_ctrl", 32'(ctrl), 32'(C_STORE));
        chk("store_valid", 32'(out_valid), 32'd1);
        tick();
        chk("store_once", 32'(out_valid), 32'd0);

        // back-to-back legal decode table
        vecs[0] = '{7'b0110011, 3'b000, C_OP};
        vecs[1] = '{7'b1100011, 3'b000, C_BRANCH};
        vecs[2] = '{7'b0010011, 3'b101, C_OPIMM};
        vecs[3] = '{7'b1101111, 3'b111, C_JAL};
        vecs[4] = '{7'b1100111, 3'b000, C_JALR};
        vecs[5] = '{7'b0010111, 3'b011, C_AUIPC};
        vecs[6] = '{7'b0000011, 3'b101, C_LOAD};
        vecs[7] = '{7'b1100011, 3'b111, C_BRANCH};
        for (int i = 0; i < 8; i++) begin
            op = vecs[i].o; funct3 = vecs[i].f3; in_valid = 1'b1;
            tick();
            chk("tbl_ctrl", 32'(ctrl), 32'(vecs[i].c));
            chk("tbl_flags", 32'({out_valid, illegal, busy}), 32'b100);
        end
        in_valid = 1'b0;
        tick();

        // FENCE drain: in_ready low for exactly 4 cycles after the accept edge
        issue(7'b0001111, 3'b000);
        chk("fence_flag", 32'(is_fence), 32'd1);
        chk("fence_ctrl", 32'(ctrl), 32'd0);
        chk("fence_ill", 32'(illegal), 32'd0);
        chk("fence_busy", 32'(busy), 32'd1);
        low_cnt = 0;
        while (!in_ready && low_cnt < 20) begin
            low_cnt++;
            tick();
        end
        chk("fence_drain_len", 32'(low_cnt), 32'd4);
        chk("fence_done_busy", 32'(busy), 32'd0);

        // trap entries
        trap_case("jalr_f3", 7'b1100111, 3'b001, 1'b1, 1'b0);
        trap_case("unk_op", 7'b1111111, 3'b000, 1'b1, 1'b0);
        trap_case("load_f3", 7'b0000011, 3'b110, 1'b1, 1'b0);
        trap_case("store_f3", 7'b0100011, 3'b011, 1'b1, 1'b0);
        trap_case("branch_f3", 7'b1100011, 3'b010, 1'b1, 1'b0);
        trap_case("system", 7'b1110011, 3'b000, 1'b0, 1'b1);
        tick();

        // trap_ack outside TRAP has no effect
        trap_ack = 1'b1;
        issue(7'b0110111, 3'b000);
        trap_ack = 1'b0;
        chk("ack_run_busy", 32'(busy), 32'd0);
        chk("ack_run_ctrl", 32'(ctrl), 32'(C_LUI));
        tick();

        // flush during DRAIN with an instruction presented
        out_ready = 1'b0;
        issue(7'b0001111, 3'b000);
        chk("fl_drain_busy", 32'(busy), 32'd1);
        flush = 1'b1; op = 7'b0110111; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_drain_valid", 32'(out_valid), 32'd0);
        chk("fl_drain_busy0", 32'(busy), 32'd0);
        chk("fl_drain_flags", 32'({is_fence, ctrl}), 32'd0);
        tick();
        chk("fl_drain_noemit", 32'(out_valid), 32'd0);

        // flush beats an accept in RUN
        out_ready = 1'b1;
        flush = 1'b1; op = 7'b0000011; funct3 = 3'b000; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_run_valid", 32'(out_valid), 32'd0);
        chk("fl_run_ctrl", 32'(ctrl), 32'd0);

        // asynchronous reset while holding in TRAP with a valid bundle
        out_ready = 1'b0;
        issue(7'b1110011, 3'b000);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sys", 32'(is_system), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("arst_rdy", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
